// File: rtl/regfile_arbiter_pkg.sv
// regfile_arbiter_pkg: arbiter state encoding and requester ids
package regfile_arbiter_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, WAIT_RD = 2'b10} state_t;
  localparam logic REQ_CTRL = 1'b0;
  localparam logic REQ_DBG = 1'b1;
endpackage

// File: rtl/regfile_rr_pick.sv
// regfile_rr_pick: combinational 2-way round-robin pick, the requester that is not last wins a tie
module regfile_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);
  assign any = |req;
  assign win = &req ? ~last : req[1];
endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of the single-port regfile between two requesters,
// with a read timeout so a missing rd_d_valid cannot deadlock the arbiter
module regfile_arbiter
  import regfile_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDRESS    = 4,
  parameter int TIMEOUT    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  r0_req,
  input  logic                  r0_we,
  input  logic [ADDRESS-1:0]    r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic                  r0_rerr,
  input  logic                  r1_req,
  input  logic                  r1_we,
  input  logic [ADDRESS-1:0]    r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  r1_rerr,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic [ADDRESS-1:0]    addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  rd_d_valid
);
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic last, owner, we_q, win, any, issue, done, timeout;
  logic [ADDRESS-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [CW-1:0] cnt;
  regfile_rr_pick u_pick (.req({r1_req, r0_req}), .last(last), .win(win), .any(any));
  assign timeout = cnt == CW'(TIMEOUT - 1);
  assign addr = addr_q;
  // Strobes come only from state and capture flops, never from live requester inputs
  always_comb begin
    issue = state == ISSUE;
    done = state == WAIT_RD && (rd_d_valid || timeout);
    state_n = state == IDLE ? (any ? ISSUE : IDLE) :
              issue ? (we_q ? IDLE : WAIT_RD) :
              state == WAIT_RD ? (done ? IDLE : WAIT_RD) : IDLE;
    r0_gnt = issue && owner == REQ_CTRL;
    r1_gnt = issue && owner == REQ_DBG;
    wr_en = issue && we_q;
    rd_en = issue && !we_q;
    wr_data = issue && we_q ? wdata_q : '0;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      last <= 1'b1;
      owner <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      cnt <= '0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_rdata <= '0;
      r1_rdata <= '0;
      r0_rerr <= 1'b0;
      r1_rerr <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= state == WAIT_RD ? cnt + 1'b1 : '0;
      r0_rvalid <= done && owner == REQ_CTRL;
      r1_rvalid <= done && owner == REQ_DBG;
      if (state == IDLE && any) begin
        last <= win;
        owner <= win;
        we_q <= win ? r1_we : r0_we;
        addr_q <= win ? r1_addr : r0_addr;
        wdata_q <= win ? r1_wdata : r0_wdata;
      end
      if (done && owner == REQ_CTRL) begin
        r0_rdata <= rd_d_valid ? rd_data : '0;
        r0_rerr <= !rd_d_valid;
      end
      if (done && owner == REQ_DBG) begin
        r1_rdata <= rd_d_valid ? rd_data : '0;
        r1_rerr <= !rd_d_valid;
      end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: directed scenarios against a schedule-based model checked every cycle
module tb_regfile_arbiter;
  localparam int DW = 8, AW = 4, TO = 4;
  typedef struct {logic we; logic [AW-1:0] a; logic [DW-1:0] d;} txn_t;
  logic clk = 0, rst;
  logic r0_req, r0_we, r1_req, r1_we;
  logic [AW-1:0] r0_addr, r1_addr, addr;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, wr_data, rd_data;
  logic r0_gnt, r0_rvalid, r0_rerr, r1_gnt, r1_rvalid, r1_rerr, wr_en, rd_en, rd_d_valid;
  logic auto_v = 0, man_v = 0;
  logic [DW-1:0] auto_d = 0, man_d = 0;
  assign rd_d_valid = auto_v | man_v;
  assign rd_data = auto_v ? auto_d : man_d;
  txn_t q0[$], q1[$];
  logic [DW-1:0] mem [16];
  bit resp_en = 0, rs_seen, g0, g1;
  logic [AW-1:0] rs_a;
  int checks = 0, errors = 0, cyc = 0;
  int gl_who[$], gl_cyc[$], rv_who[$], rv_cyc[$];
  logic gl_we[$], rv_err[$];
  logic [AW-1:0] gl_addr[$];
  logic [DW-1:0] gl_wd[$];
  // model: when the arbiter is next free, who owns the current access, and expected outputs
  int m_free = 0, m_own = 0, m_issue = -100, m_last = 1;
  bit m_pend = 0, m_wr = 0, e_wr_en = 0, e_rd_en = 0;
  bit e_gnt[2], e_rv[2], e_err[2];
  logic [AW-1:0] e_addr = 0;
  logic [DW-1:0] e_wd = 0, e_rdata[2];

  regfile_arbiter #(.DATA_WIDTH(DW), .ADDRESS(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata), .r0_rerr(r0_rerr),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata), .r1_rerr(r1_rerr),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .rd_d_valid(rd_d_valid));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, a, e, cyc);
    end
  endtask

  task automatic model_reset();
    m_free = 0; m_issue = -100; m_last = 1; m_pend = 0; m_wr = 0;
    e_wr_en = 0; e_rd_en = 0; e_addr = 0; e_wd = 0;
    e_gnt = '{0, 0}; e_rv = '{0, 0}; e_err = '{0, 0}; e_rdata = '{0, 0};
  endtask

  task automatic model_step();
    e_gnt = '{0, 0}; e_rv = '{0, 0}; e_wr_en = 0; e_rd_en = 0; e_wd = 0;
    if (m_pend && cyc > m_issue && (rd_d_valid || cyc == m_issue + TO)) begin
      e_rdata[m_own] = rd_d_valid ? rd_data : '0;
      e_err[m_own] = !rd_d_valid;
      e_rv[m_own] = 1;
      m_pend = 0;
      m_free = cyc + 1;
    end else if (!m_pend && cyc >= m_free && (r0_req || r1_req)) begin
      m_own = (r0_req && r1_req) ? (m_last == 1 ? 0 : 1) : (r1_req ? 1 : 0);
      m_last = m_own;
      m_issue = cyc + 1;
      e_gnt[m_own] = 1;
      m_wr = m_own == 1 ? r1_we : r0_we;
      e_addr = m_own == 1 ? r1_addr : r0_addr;
      if (m_wr) begin
        e_wr_en = 1;
        e_wd = m_own == 1 ? r1_wdata : r0_wdata;
        m_free = cyc + 2;
      end else begin
        e_rd_en = 1;
        m_pend = 1;
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst) model_reset();
    chk("gnt0", 32'(r0_gnt), 32'(e_gnt[0]));
    chk("gnt1", 32'(r1_gnt), 32'(e_gnt[1]));
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    chk("rd_en", 32'(rd_en), 32'(e_rd_en));
    chk("addr", 32'(addr), 32'(e_addr));
    chk("wr_data", 32'(wr_data), 32'(e_wd));
    chk("rvalid0", 32'(r0_rvalid), 32'(e_rv[0]));
    chk("rvalid1", 32'(r1_rvalid), 32'(e_rv[1]));
    chk("rdata0", 32'(r0_rdata), 32'(e_rdata[0]));
    chk("rdata1", 32'(r1_rdata), 32'(e_rdata[1]));
    if (e_rv[0] || !rst) chk("rerr0", 32'(r0_rerr), 32'(e_err[0]));
    if (e_rv[1] || !rst) chk("rerr1", 32'(r1_rerr), 32'(e_err[1]));
    if (r0_gnt || r1_gnt) begin
      gl_who.push_back(r1_gnt ? 1 : 0); gl_cyc.push_back(cyc);
      gl_we.push_back(wr_en); gl_addr.push_back(addr); gl_wd.push_back(wr_data);
    end
    if (r0_rvalid || r1_rvalid) begin
      rv_who.push_back(r1_rvalid ? 1 : 0); rv_cyc.push_back(cyc);
      rv_err.push_back(r1_rvalid ? r1_rerr : r0_rerr);
    end
    if (rst) model_step();
  end

  // requester agents: present the queue head, advance on the edge after a grant
  initial forever begin
    @(negedge clk); g0 = r0_gnt; g1 = r1_gnt;
    @(posedge clk); #1;
    if (g0 && q0.size() > 0) q0.delete(0);
    if (g1 && q1.size() > 0) q1.delete(0);
    r0_req = rst && q0.size() > 0;
    r1_req = rst && q1.size() > 0;
    if (q0.size() > 0) begin r0_we = q0[0].we; r0_addr = q0[0].a; r0_wdata = q0[0].d; end
    if (q1.size() > 0) begin r1_we = q1[0].we; r1_addr = q1[0].a; r1_wdata = q1[0].d; end
  end

  // regfile with one-cycle read latency, enabled per scenario
  initial forever begin
    @(negedge clk); rs_seen = resp_en && rd_en; rs_a = addr;
    @(posedge clk); #1; auto_v = rs_seen; auto_d = mem[rs_a];
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 0; q0.delete(); q1.delete();
    repeat (2) @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic pulse(input logic [DW-1:0] d);
    @(posedge clk); #1; man_v = 1; man_d = d;
    @(posedge clk); #1; man_v = 0;
  endtask

  initial begin
    int b, rb;
    rst = 0;
    r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0;
    r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0;
    foreach (mem[i]) mem[i] = 8'h00;
    mem[2] = 8'h11; mem[7] = 8'h77;
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'({r0_gnt, r1_gnt, wr_en, rd_en}), 0);
    chk("rst_addr", 32'(addr), 0);
    chk("rst_rdata", 32'({r0_rdata, r1_rdata}), 0);
    @(posedge clk); #1; rst = 1;
    // single write from r0
    cycles(1); b = gl_who.size();
    q0.push_back('{1'b1, 4'd3, 8'h5A});
    cycles(6);
    chk("s1_count", 32'(gl_who.size() - b), 1);
    chk("s1_who", 32'(gl_who[b]), 0);
    chk("s1_we", 32'(gl_we[b]), 1);
    chk("s1_addr", 32'(gl_addr[b]), 3);
    chk("s1_wdata", 32'(gl_wd[b]), 32'h5A);
    // both read from reset, regfile latency 1
    do_reset(); resp_en = 1;
    cycles(1); b = gl_who.size(); rb = rv_who.size();
    q0.push_back('{1'b0, 4'd2, 8'h00});
    q1.push_back('{1'b0, 4'd7, 8'h00});
    cycles(12);
    resp_en = 0;
    chk("s2_count", 32'(gl_who.size() - b), 2);
    chk("s2_first", 32'(gl_who[b]), 0);
    chk("s2_second", 32'(gl_who[b+1]), 1);
    chk("s2_rvcount", 32'(rv_who.size() - rb), 2);
    chk("s2_lat", 32'(rv_cyc[rb] - gl_cyc[b]), 2);
    chk("s2_rerr", 32'({rv_err[rb], rv_err[rb+1]}), 0);
    chk("s2_rdata0", 32'(r0_rdata), 32'h11);
    chk("s2_rdata1", 32'(r1_rdata), 32'h77);
    // r1 read with no rd_d_valid times out
    b = gl_who.size(); rb = rv_who.size();
    q1.push_back('{1'b0, 4'd5, 8'h00});
    cycles(12);
    chk("s4_who", 32'(gl_who[b]), 1);
    chk("s4_rvcount", 32'(rv_who.size() - rb), 1);
    chk("s4_delay", 32'(rv_cyc[rb] - gl_cyc[b]), TO + 1);
    chk("s4_rerr", 32'(rv_err[rb]), 1);
    chk("s4_rdata1", 32'(r1_rdata), 0);
    chk("s4_rdata0", 32'(r0_rdata), 32'h11);
    rb = rv_who.size();
    pulse(8'hFF); cycles(2);
    chk("s4_late", 32'(r1_rdata), 0);
    chk("s4_late_rv", 32'(rv_who.size() - rb), 0);
    // stray rd_d_valid while idle
    pulse(8'hAB); cycles(2);
    chk("s6_rv", 32'(rv_who.size() - rb), 0);
    chk("s6_rdata0", 32'(r0_rdata), 32'h11);
    chk("s6_rdata1", 32'(r1_rdata), 0);
    // continuous writes from both: strict alternation every 2 cycles
    do_reset();
    cycles(1); b = gl_who.size();
    for (int i = 0; i < 4; i++) begin
      q0.push_back('{1'b1, AW'(i), DW'(8'h10 + i)});
      q1.push_back('{1'b1, AW'(8 + i), DW'(8'h20 + i)});
    end
    cycles(24);
    chk("s3_count", 32'(gl_who.size() - b), 8);
    for (int i = 0; i < 8; i++) begin
      chk("s3_order", 32'(gl_who[b+i]), 32'(i % 2));
      if (i > 0) chk("s3_spacing", 32'(gl_cyc[b+i] - gl_cyc[b+i-1]), 2);
    end
    // reset during WAIT_RD
    cycles(1); b = gl_who.size();
    q0.push_back('{1'b0, 4'd2, 8'h00});
    cycles(4);
    chk("s5_issued", 32'(gl_who.size() - b), 1);
    rb = rv_who.size();
    do_reset();
    cycles(1);
    pulse(8'h33); cycles(3);
    chk("s5_no_rv", 32'(rv_who.size() - rb), 0);
    chk("s5_rdata0", 32'(r0_rdata), 0);
    b = gl_who.size();
    q1.push_back('{1'b1, 4'd1, 8'h44});
    q0.push_back('{1'b1, 4'd6, 8'h55});
    cycles(8);
    chk("s5_count", 32'(gl_who.size() - b), 2);
    chk("s5_first", 32'(gl_who[b]), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end
endmodule
